// File: rtl/coco_audio_mixer.sv
// Mixes the CoCo DAC, single-bit sound and cassette monitor into one level, low-pass
// filters it at clk rate, then decimates to SAMPLE_HZ through a DC blocker.
module coco_audio_mixer #(
  parameter int unsigned CLK_HZ    = 57272000,
  parameter int unsigned SAMPLE_HZ = 48000,
  parameter int unsigned LP_SHIFT  = 10,
  parameter int unsigned DC_SHIFT  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  sound,
  input  logic        sndout,
  input  logic        casdout,
  input  logic        cas_mon,
  input  logic        mute,
  output logic [15:0] audio_out,
  output logic        sample_valid
);

  localparam int unsigned LpW = 16 + LP_SHIFT;
  localparam int unsigned DcW = 16 + DC_SHIFT;
  localparam int unsigned PhW = $clog2(CLK_HZ + SAMPLE_HZ + 1);

  logic [15:0]      x_q, x_d;
  logic [LpW-1:0]   lp_acc_q, lp_acc_d;
  logic [DcW-1:0]   dc_acc_q, dc_acc_d;
  logic [PhW-1:0]   ph_q, ph_d;
  logic [15:0]      audio_q, audio_d;
  logic             valid_q, valid_d;

  logic [15:0]        y;
  logic [15:0]        dc;
  logic [PhW-1:0]     ph_sum;
  logic               strobe;
  logic signed [16:0] diff;
  logic [15:0]        sat;

  // Both IIRs settle exactly on the input level because the leak term is the
  // truncated filter output itself; ph never exceeds CLK_HZ+SAMPLE_HZ, so no drift.
  always_comb begin
    x_d = {1'b0, sound, 9'b0}
        + (sndout ? 16'd8192 : 16'd0)
        + ((casdout & cas_mon) ? 16'd4096 : 16'd0);

    y  = lp_acc_q[LpW-1:LP_SHIFT];
    dc = dc_acc_q[DcW-1:DC_SHIFT];

    lp_acc_d = lp_acc_q + LpW'(x_q) - LpW'(y);

    ph_sum = ph_q + PhW'(SAMPLE_HZ);
    strobe = (ph_sum >= PhW'(CLK_HZ));
    ph_d   = strobe ? (ph_sum - PhW'(CLK_HZ)) : ph_sum;

    dc_acc_d = strobe ? (dc_acc_q + DcW'(y) - DcW'(dc)) : dc_acc_q;

    diff = $signed({1'b0, y}) - $signed({1'b0, dc});
    if (diff[16] != diff[15]) begin
      sat = diff[16] ? 16'h8000 : 16'h7fff;
    end else begin
      sat = diff[15:0];
    end

    audio_d = audio_q;
    if (strobe) begin
      audio_d = mute ? 16'd0 : sat;
    end
    valid_d = strobe;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      lp_acc_q <= '0;
      dc_acc_q <= '0;
      ph_q     <= '0;
      audio_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      lp_acc_q <= lp_acc_d;
      dc_acc_q <= dc_acc_d;
      ph_q     <= ph_d;
      audio_q  <= audio_d;
      valid_q  <= valid_d;
    end
  end

  assign audio_out    = audio_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_coco_audio_mixer.sv
// Scoreboard bench for coco_audio_mixer: a spec-level model queues expected samples,
// a negedge monitor pops them on sample_valid; scaled rates keep the run short.
module tb_coco_audio_mixer;

  localparam int CLK_HZ    = 57272;
  localparam int SAMPLE_HZ = 4800;
  localparam int LP_SHIFT  = 4;
  localparam int DC_SHIFT  = 4;
  localparam int CADENCE   = 57272;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  sound = '0;
  logic        sndout = 1'b0;
  logic        casdout = 1'b0;
  logic        cas_mon = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] audio_out;
  logic        sample_valid;

  coco_audio_mixer #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .LP_SHIFT(LP_SHIFT), .DC_SHIFT(DC_SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .sound(sound), .sndout(sndout), .casdout(casdout),
    .cas_mon(cas_mon), .mute(mute), .audio_out(audio_out), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  longint expQ[$];
  longint mX = 0, mLp = 0, mDc = 0, mPh = 0;
  int cyc = 0;
  int epoch = 0;

  int statValid, statNonZero;
  longint statMin, statMax, lastSample;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input longint actual, input longint lo, input longint hi);
    vectors++;
    if (actual < lo || actual > hi) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic resetStats();
    statValid = 0; statNonZero = 0;
    statMin = 64'sd100000; statMax = -64'sd100000; lastSample = 0;
  endtask

  // Reference model of the mixer equations, advanced once per clock edge.
  task automatic modelStep();
    longint yv, dcv, d;
    if (reset) begin
      mX = 0; mLp = 0; mDc = 0; mPh = 0; cyc = 0;
    end else begin
      yv  = mLp >> LP_SHIFT;
      dcv = mDc >> DC_SHIFT;
      if (mPh + SAMPLE_HZ >= CLK_HZ) begin
        d = yv - dcv;
        if (d > 32767) d = 32767;
        else if (d < -32768) d = -32768;
        if (mute) d = 0;
        expQ.push_back(d);
        mPh = mPh + SAMPLE_HZ - CLK_HZ;
        mDc = mDc + yv - dcv;
      end else begin
        mPh = mPh + SAMPLE_HZ;
      end
      mLp = mLp + mX - yv;
      mX  = longint'(sound) * 512 + (sndout ? 8192 : 0) + ((casdout && cas_mon) ? 4096 : 0);
      cyc++;
    end
  endtask

  task automatic applyStimulus(input int n);
    longint s;
    repeat (n) begin
      @(posedge clk);
      modelStep();
      #1;
      if (sample_valid) begin
        s = longint'($signed(audio_out));
        statValid++;
        if (s != 0) statNonZero++;
        if (s < statMin) statMin = s;
        if (s > statMax) statMax = s;
        lastSample = s;
      end
    end
  endtask

  int toneCyc = 0;
  task automatic toneTick();
    sound = ((toneCyc / 20) % 2) ? 6'd63 : 6'd0;
    toneCyc++;
    applyStimulus(1);
  endtask

  bit prevValid = 1'b0;
  bit firstSeen = 1'b0;
  int pulseCount = 0;
  int lastPulseCyc = 0;
  int gapBad = 0;
  longint expSample;

  always @(negedge clk) begin
    if (sample_valid) begin
      checkOutput("back_to_back", longint'(prevValid), 0);
      checkOutput("queue_nonempty", longint'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        expSample = expQ.pop_front();
        checkOutput("sample", longint'($signed(audio_out)), expSample);
      end
      if (!firstSeen) begin
        firstSeen = 1'b1;
        checkOutput("first_pulse_cycle", cyc, 12);
      end else if ((cyc - lastPulseCyc) != 11 && (cyc - lastPulseCyc) != 12) begin
        gapBad++;
      end
      lastPulseCyc = cyc;
      if (epoch == 1 && cyc <= CADENCE) pulseCount++;
    end
    prevValid = sample_valid;
  end

  bit seen;
  int mutedPulses;

  initial begin
    resetStats();
    reset = 1'b1;
    applyStimulus(3);
    checkOutput("reset_audio", audio_out, 0);
    checkOutput("reset_valid", sample_valid, 0);

    epoch = 1;
    reset = 1'b0;
    sound = 6'd63; sndout = 1'b1;
    resetStats();
    applyStimulus(3000);
    checkOutput("mix_sat", dut.x_q, 40448);
    checkOutput("sat_max", statMax, 32767);
    checkRange("sat_never_negative", statMin, 0, 32767);

    sound = 6'd0; sndout = 1'b0;
    resetStats();
    applyStimulus(200);
    checkOutput("fall_min", statMin, -32768);
    applyStimulus(4000);

    casdout = 1'b1; cas_mon = 1'b0;
    resetStats();
    applyStimulus(500);
    checkOutput("cas_gate_x", dut.x_q, 0);
    checkOutput("cas_gate_nonzero", statNonZero, 0);
    cas_mon = 1'b1;
    resetStats();
    applyStimulus(300);
    checkOutput("cas_x", dut.x_q, 4096);
    checkRange("cas_transient_max", statMax, 1, 4096);

    casdout = 1'b0; cas_mon = 1'b0; sound = 6'd63;
    resetStats();
    applyStimulus(5000);
    checkOutput("lp_y", longint'(dut.lp_acc_q >> LP_SHIFT), 32256);
    checkRange("lp_settled_out", lastSample, -2, 2);

    for (int i = 0; i < 400; i++) toneTick();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      toneTick();
      seen = sample_valid;
    end
    checkOutput("mute_sync", longint'(seen), 1);
    mute = 1'b1;
    mutedPulses = 0;
    for (int i = 0; i < 100 && mutedPulses < 3; i++) begin
      toneTick();
      if (sample_valid) begin
        mutedPulses++;
        checkOutput("mute_zero", audio_out, 0);
      end
    end
    mute = 1'b0;
    checkOutput("mute_pulses", mutedPulses, 3);
    checkOutput("mute_lp_acc", longint'(dut.lp_acc_q), mLp);
    checkOutput("mute_dc_acc", longint'(dut.dc_acc_q), mDc);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      toneTick();
      seen = sample_valid;
    end
    checkOutput("unmute_pulse", longint'(seen), 1);

    sound = 6'd40;
    for (int i = 0; i < 70000 && cyc <= CADENCE; i++) applyStimulus(1);
    checkOutput("cadence_pulses", pulseCount, 4800);
    checkOutput("cadence_gaps", gapBad, 0);

    sound = 6'd63; sndout = 1'b1;
    applyStimulus(5);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (mPh + SAMPLE_HZ >= CLK_HZ) seen = 1'b1;
      else applyStimulus(1);
    end
    checkOutput("strobe_found", longint'(seen), 1);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("rst_valid", sample_valid, 0);
    checkOutput("rst_audio", audio_out, 0);
    checkOutput("rst_x", dut.x_q, 0);
    checkOutput("rst_lp", longint'(dut.lp_acc_q), 0);
    checkOutput("rst_dc", longint'(dut.dc_acc_q), 0);
    checkOutput("rst_ph", longint'(dut.ph_q), 0);
    epoch = 2;
    firstSeen = 1'b0;
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("rst_valid_next", sample_valid, 0);
    applyStimulus(100);
    checkOutput("restart_pulse_seen", longint'(firstSeen), 1);
    @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
